fifo_unpack: RTL and testbench

FIFO_UNPACK -- requirements
Module: fifo_unpack

---
 rtl/fifo_unpack.sv | 93 +++++++++
 tb/tb_fifo_unpack.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_unpack.sv
// Reads wide words from an upstream FIFO and replays them MSB-first as a byte
// stream with valid/ready/last handshaking and a count of completed words.
module fifo_unpack #(
  parameter int DATA_WIDTH = 72,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_done
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                 state_q;
  logic                   pop_q;
  logic [DATA_WIDTH-1:0]  shift_q;
  logic [DATA_WIDTH-1:0]  shift_d;
  logic [IDX_W-1:0]       idx_q;
  logic [IDX_W-1:0]       idx_d;
  logic [7:0]             out_data_q;
  logic                   out_valid_q;
  logic                   out_last_q;
  logic [CNT_WIDTH-1:0]   words_q;
  logic                   accept;

  // pop_q blocks a pop in the cycle where the upstream empty/dout are still stale
  assign fifo_rd_en = (state_q == IDLE) && !fifo_empty && !pop_q && !clr;
  assign busy       = (state_q == SEND);
  assign accept     = out_valid_q && out_ready;
  assign shift_d    = shift_q << 8;
  assign idx_d      = idx_q + 1'b1;

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign words_done = words_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      pop_q       <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      words_q     <= '0;
    end else begin
      pop_q <= fifo_rd_en;
      case (state_q)
        IDLE: begin
          if (fifo_rd_en) begin
            shift_q     <= fifo_dout;
            idx_q       <= '0;
            out_data_q  <= fifo_dout[DATA_WIDTH-1 -: 8];
            out_valid_q <= 1'b1;
            out_last_q  <= (NBYTES == 1);
            state_q     <= SEND;
          end
        end
        SEND: begin
          // Without a handshake every output register simply holds its value
          if (accept) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              words_q     <= words_q + 1'b1;
              state_q     <= IDLE;
            end else begin
              shift_q    <= shift_d;
              idx_q      <= idx_d;
              out_data_q <= shift_d[DATA_WIDTH-1 -: 8];
              out_last_q <= (idx_d == LAST_IDX);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_unpack.sv
// Scoreboard bench for fifo_unpack: an upstream FIFO model with stale flags feeds
// the DUT, expected bytes are queued at push time and popped by a monitor.
module tb_fifo_unpack;

  localparam int DW = 72;
  localparam int CW = 2;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          clr;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic          busy;
  logic [CW-1:0] words_done;

  logic [DW-1:0] fq[$];
  logic [8:0]    expQ[$];
  logic [CW-1:0] expWords = '0;
  int            nCompared = 0;
  int            nMismatched = 0;
  logic          monOn = 1'b0;
  logic          prevRd = 1'b0;
  logic          holdPrev = 1'b0;
  logic [7:0]    holdData = '0;
  logic          holdLast = 1'b0;
  logic [8:0]    monE;

  fifo_unpack #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .clr        (clr),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy),
    .words_done (words_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] randWord();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // Enqueue a word upstream and its bytes, MSB first, in the scoreboard
  task automatic applyStimulus(input logic [DW-1:0] w);
    fq.push_back(w);
    for (int i = 0; i < NB; i++)
      expQ.push_back({i == NB - 1, 8'((w >> (8 * (NB - 1 - i))) & 72'hFF)});
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((expQ.size() != 0 || fq.size() != 0 || out_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL drain_timeout: got %0d bytes pending expected 0", expQ.size());
    end
  endtask

  // Upstream FIFO: empty and dout are registered from the pre-pop contents,
  // so both are stale for one cycle after each pop
  always @(posedge clk) begin
    if (clr) begin
      fq.delete();
      fifo_empty <= 1'b1;
      fifo_dout  <= '0;
    end else begin
      fifo_empty <= (fq.size() == 0);
      fifo_dout  <= (fq.size() > 0) ? fq[0] : '0;
      if (fifo_rd_en) begin
        checkOutput("pop_nonempty", DW'(fq.size() > 0), 1);
        if (fq.size() > 0) void'(fq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (monOn) begin
      checkOutput("words_done", DW'(words_done), DW'(expWords));
      if (fifo_rd_en) checkOutput("rd_en_spacing", DW'(prevRd), 0);
      prevRd = fifo_rd_en;
      if (holdPrev) begin
        checkOutput("hold_valid", DW'(out_valid), 1);
        checkOutput("hold_data", DW'(out_data), DW'(holdData));
        checkOutput("hold_last", DW'(out_last), DW'(holdLast));
      end
      holdPrev = out_valid && !out_ready && !clr;
      holdData = out_data;
      holdLast = out_last;
      if (clr) begin
        checkOutput("rd_en_in_clr", DW'(fifo_rd_en), 0);
        expQ.delete();
        expWords = '0;
      end else if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("[TB] FAIL unexpected_byte: got %0h expected none", out_data);
        end else begin
          monE = expQ.pop_front();
          checkOutput("byte", DW'(out_data), DW'(monE[7:0]));
          checkOutput("last", DW'(out_last), DW'(monE[8]));
          if (monE[8]) expWords = expWords + 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int run, nValid, nRd, firstV, lastV, inner, maxRun, curRun, k;
    logic [44:0] vHist;
    int wrapTab[5] = '{1, 2, 3, 0, 1};

    clr = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", DW'(out_valid), 0);
    checkOutput("rst_last", DW'(out_last), 0);
    checkOutput("rst_data", DW'(out_data), 0);
    checkOutput("rst_busy", DW'(busy), 0);
    checkOutput("rst_words", DW'(words_done), 0);
    checkOutput("rst_rd_en", DW'(fifo_rd_en), 0);
    @(posedge clk); #1;
    clr = 1'b0;
    monOn = 1'b1;

    $display("[TB] single word");
    out_ready = 1'b1;
    applyStimulus(72'h010203040506070809);
    run = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) run++;
      else if (run > 0) break;
    end
    checkOutput("single_run", DW'(run), 9);
    checkOutput("single_words", DW'(words_done), 1);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(72'h010203040506070809);
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 50);
    checkOutput("bp_start", DW'(out_valid), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_data", DW'(out_data), 8'h03);
      checkOutput("bp_valid", DW'(out_valid), 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    waitDrain(100);

    $display("[TB] empty upstream");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("empty_rd_en", DW'(fifo_rd_en), 0);
      checkOutput("empty_valid", DW'(out_valid), 0);
      checkOutput("empty_busy", DW'(busy), 0);
    end

    $display("[TB] back-to-back");
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) applyStimulus(randWord());
    nRd = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      vHist[i] = out_valid;
      if (fifo_rd_en) nRd++;
    end
    nValid = 0; firstV = -1; lastV = -1;
    for (int i = 0; i < 45; i++) if (vHist[i]) begin
      nValid++;
      if (firstV < 0) firstV = i;
      lastV = i;
    end
    inner = 0; maxRun = 0; curRun = 0;
    for (int i = 0; i < 45; i++) if (i > firstV && i < lastV) begin
      if (!vHist[i]) begin inner++; curRun++; if (curRun > maxRun) maxRun = curRun; end
      else curRun = 0;
    end
    checkOutput("b2b_bytes", DW'(nValid), 27);
    checkOutput("b2b_pops", DW'(nRd), 3);
    checkOutput("b2b_idle_total", DW'(inner), 2);
    checkOutput("b2b_idle_run", DW'(maxRun), 1);
    waitDrain(100);

    $display("[TB] reset mid-word");
    applyStimulus(72'h010203040506070809);
    k = 0;
    do begin @(negedge clk); k++; end while (!(out_valid && out_data == 8'h04) && k < 50);
    checkOutput("mid_reach_04", DW'(out_data), 8'h04);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    checkOutput("mid_valid", DW'(out_valid), 0);
    checkOutput("mid_busy", DW'(busy), 0);
    checkOutput("mid_words", DW'(words_done), 0);
    @(posedge clk); #1;
    applyStimulus(72'hA1A2A3A4A5A6A7A8A9);
    waitDrain(100);

    $display("[TB] counter wrap");
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(randWord());
      waitDrain(100);
      checkOutput("wrap_words", DW'(words_done), DW'(wrapTab[i]));
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0 && fq.size() < 4) applyStimulus(randWord());
    end
    out_ready = 1'b1;
    waitDrain(500);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
